// File: rtl/tpu_pkg.sv
// Shared TPU constants, drain FSM state type and the per-lane requant function.
package tpu_pkg;

    localparam int ADDRESSSIZE    = 10;
    localparam int MATRIX_SIZE    = 16;
    localparam int PARTIAL_SUM_BW = 24;
    localparam int DATA_BW        = 8;
    localparam int SHIFT_BW       = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } drain_state_e;

    // Largest meaningful shift; anything above is clamped here.
    localparam logic [SHIFT_BW-1:0] MAX_SHIFT = SHIFT_BW'(PARTIAL_SUM_BW - 1);
    // Saturation bounds of the signed output, held in the 25-bit working width.
    localparam logic signed [PARTIAL_SUM_BW:0] SAT_HI = (PARTIAL_SUM_BW+1)'(2**(DATA_BW-1) - 1);
    localparam logic signed [PARTIAL_SUM_BW:0] SAT_LO = (PARTIAL_SUM_BW+1)'(-(2**(DATA_BW-1)));

    // Round-half-up arithmetic shift followed by signed saturation to DATA_BW.
    // One extra bit of headroom keeps x + rounding constant from overflowing.
    function automatic logic [DATA_BW-1:0] sat_round_shift(
        input logic [PARTIAL_SUM_BW-1:0] psum,
        input logic [SHIFT_BW-1:0]       shamt
    );
        logic [SHIFT_BW-1:0]             s;
        logic signed [PARTIAL_SUM_BW:0]  rnd;
        logic signed [PARTIAL_SUM_BW:0]  sum;
        logic signed [PARTIAL_SUM_BW:0]  y;
        s   = (shamt > MAX_SHIFT) ? MAX_SHIFT : shamt;
        rnd = (s == '0) ? '0 : ((PARTIAL_SUM_BW+1)'(1) << (s - SHIFT_BW'(1)));
        sum = $signed({psum[PARTIAL_SUM_BW-1], psum}) + rnd;
        y   = sum >>> s;
        if (y > SAT_HI)
            y = SAT_HI;
        else if (y < SAT_LO)
            y = SAT_LO;
        return y[DATA_BW-1:0];
    endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of the result requantizer: 24-bit partial sum -> saturated 8-bit.
module requant_lane
    import tpu_pkg::*;
(
    input  logic [PARTIAL_SUM_BW-1:0] i_psum,
    input  logic [SHIFT_BW-1:0]       i_shift,
    output logic [DATA_BW-1:0]        o_q
);

    // Purely combinational; the shift is constant for the whole drain.
    assign o_q = sat_round_shift(i_psum, i_shift);

endmodule

// File: rtl/result_drain_ctrl.sv
// Reads a tile of result rows from the results SRAM, requantizes each lane and
// streams packed 128-bit rows out through a 2-entry skid FIFO.
module result_drain_ctrl
    import tpu_pkg::*;
(
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic [ADDRESSSIZE-1:0]              base_addr,
    input  logic [ADDRESSSIZE:0]                num_rows,
    input  logic [SHIFT_BW-1:0]                 shift,
    output logic                                rd_en,
    output logic [ADDRESSSIZE-1:0]              rd_addr,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] rd_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_BW*MATRIX_SIZE-1:0]      out_data,
    output logic                                out_last,
    output logic                                busy,
    output logic                                done
);

    drain_state_e                        r_state;
    logic [ADDRESSSIZE-1:0]              r_addr;
    logic [ADDRESSSIZE:0]                r_num;
    logic [ADDRESSSIZE:0]                r_issued;
    logic [SHIFT_BW-1:0]                 r_shift;
    logic                                r_done;
    logic                                r_pend;
    logic                                r_pend_last;
    logic [MATRIX_SIZE-1:0][DATA_BW-1:0] r_fifo_data [2];
    logic [1:0]                          r_fifo_last;
    logic                                r_wr_ptr;
    logic                                r_rd_ptr;
    logic [1:0]                          r_count;

    logic [MATRIX_SIZE-1:0][DATA_BW-1:0] w_row;
    logic                                w_pop;
    logic                                w_push;
    logic                                w_issue;
    logic                                w_issue_last;
    logic                                w_last_hs;

    // Requantize the returning SRAM row, one lane instance per column.
    for (genvar g = 0; g < MATRIX_SIZE; g++) begin : g_lane
        requant_lane u_lane (
            .i_psum  (rd_data[g*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]),
            .i_shift (r_shift),
            .o_q     (w_row[g])
        );
    end

    // A slot freed by this cycle's pop counts as available, which is what
    // lets a 2-deep buffer sustain one row per cycle across the read latency.
    assign w_pop        = out_valid & out_ready;
    assign w_push       = r_pend;
    assign w_issue      = (r_state == S_RUN) && (r_issued < r_num) &&
                          (({1'b0, r_count} + {2'b00, r_pend}) < (3'd2 + {2'b00, w_pop}));
    assign w_issue_last = (r_issued == (r_num - (ADDRESSSIZE+1)'(1)));
    assign w_last_hs    = w_pop & out_last;

    assign rd_en     = w_issue;
    assign rd_addr   = r_addr;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = out_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign out_last  = out_valid & r_fifo_last[r_rd_ptr];
    assign busy      = (r_state == S_RUN);
    assign done      = r_done;

    // Drain FSM: config latch, read address/issue counter and done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_num    <= '0;
            r_issued <= '0;
            r_shift  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (num_rows != '0) begin
                            r_state  <= S_RUN;
                            r_addr   <= base_addr;
                            r_num    <= num_rows;
                            r_shift  <= shift;
                            r_issued <= '0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_addr   <= r_addr + ADDRESSSIZE'(1);
                        r_issued <= r_issued + (ADDRESSSIZE+1)'(1);
                    end
                    if (w_last_hs) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Track the read in flight so its data is captured the cycle it returns.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            r_pend      <= w_issue;
            r_pend_last <= w_issue & w_issue_last;
        end
    end

    // 2-entry FIFO between SRAM return and the output stream.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last    <= '0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_count        <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_row;
                r_fifo_last[r_wr_ptr] <= r_pend_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Randomized bench for result_drain_ctrl with a queue-based reference model.
module tb_result_drain_ctrl;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic [9:0]   base_addr = '0;
    logic [10:0]  num_rows = '0;
    logic [4:0]   shift = '0;
    logic         rd_en;
    logic [9:0]   rd_addr;
    logic [383:0] rd_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         out_last;
    logic         busy;
    logic         done;

    result_drain_ctrl dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .shift(shift), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Results SRAM: data appears one cycle after the read enable.
    logic [383:0] mem [1024];
    always @(posedge clk)
        if (rd_en) rd_data <= mem[rd_addr];

    // Reference requant from plain integer arithmetic (floor division).
    function automatic logic [7:0] m_requant(input int x, input int s);
        longint p, r, y;
        int sc;
        sc = (s > 23) ? 23 : s;
        p  = longint'(1) << sc;
        r  = longint'(x) + ((sc > 0) ? p / 2 : 64'sd0);
        if (r >= 0) y = r / p;
        else        y = -((-r + p - 1) / p);
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return y[7:0];
    endfunction

    function automatic logic [127:0] m_row(input int a, input int s);
        logic [127:0] row;
        logic [23:0]  v;
        int           x;
        for (int i = 0; i < 16; i++) begin
            v = mem[a][i*24 +: 24];
            x = {{8{v[23]}}, v};
            row[i*8 +: 8] = m_requant(x, s);
        end
        return row;
    endfunction

    // Output-ready pattern generator: 0 free, 1 = 1,0,0,1 pattern, 2 random.
    int mode = 0;
    int rp = 0;
    always @(posedge clk) begin
        #1;
        rp++;
        case (mode)
            1:       out_ready = ((rp % 4) == 0) || ((rp % 4) == 3);
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
        endcase
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    logic [127:0] exp_q [$];
    int           addr_q [$];
    logic [127:0] got_rows [64];
    bit           m_busy = 0, m_done = 0, nxt_done, hs;
    int           m_n = 0, m_addr = 0, m_issued = 0, m_beats = 0;
    int           drains_done = 0;
    int unsigned  start_cyc = 0, first_cyc = 0, last_cyc = 0;
    bit           first_seen = 0;
    bit           prev_stall = 0;
    logic [127:0] prev_data;
    logic         prev_last;

    // Single compare process: every cycle, outputs against the model.
    always @(negedge clk) begin
        if (!rstn) begin
            chk("rst_rd_en", rd_en, 0);
            chk("rst_rd_addr", rd_addr, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            m_busy = 0; m_done = 0; prev_stall = 0;
            exp_q.delete();
        end else begin
            hs = 0;
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (m_done) drains_done++;
            if (rd_en) begin
                n_cmp++;
                if (!m_busy || m_issued >= m_n) begin
                    n_err++;
                    $display("FAIL spurious_rd: rd_en at addr %0d, issued %0d of %0d", rd_addr, m_issued, m_n);
                end else begin
                    chk("rd_addr", rd_addr, m_addr);
                    addr_q.push_back(int'(rd_addr));
                    m_issued++;
                    m_addr = (m_addr + 1) % 1024;
                end
            end
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL spurious_valid: out_valid with no row expected, data %h", out_data);
                end else begin
                    chk("out_data", out_data, exp_q[0]);
                    chk("out_last", out_last, (m_beats == m_n - 1));
                    if (!first_seen) begin first_cyc = cyc; first_seen = 1; end
                    if (out_ready) begin
                        got_rows[m_beats % 64] = out_data;
                        void'(exp_q.pop_front());
                        m_beats++;
                        last_cyc = cyc;
                        hs = 1;
                    end
                end
            end
            n_cmp++;
            if (m_issued - m_beats > 2) begin
                n_err++;
                $display("FAIL outstanding: %0d rows read but not yet sent, limit 2", m_issued - m_beats);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            nxt_done = 0;
            if (m_busy && hs && m_beats == m_n) begin
                m_busy = 0;
                nxt_done = 1;
            end else if (!m_busy && !m_done && start) begin
                if (num_rows != 0) begin
                    m_busy = 1; m_n = int'(num_rows); m_addr = int'(base_addr);
                    m_issued = 0; m_beats = 0; first_seen = 0;
                    start_cyc = cyc + 1;
                    exp_q.delete();
                    for (int k = 0; k < m_n; k++)
                        exp_q.push_back(m_row((m_addr + k) % 1024, int'(shift)));
                end else begin
                    nxt_done = 1;
                end
            end
            m_done = nxt_done;
        end
    end

    task automatic do_start(input int b, input int n, input int s);
        @(posedge clk); #1;
        base_addr = 10'(b); num_rows = 11'(n); shift = 5'(s); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base_cnt, input int budget, input string name);
        bit ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (drains_done > base_cnt) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_timeout: no done within %0d cycles, beats %0d", name, budget, m_beats);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_drain(input int b, input int n, input int s, input string name);
        int c0 = drains_done;
        addr_q.delete();
        do_start(b, n, s);
        wait_done(c0, n * 10 + 50, name);
    endtask

    initial begin
        int c0;
        int tmp;
        for (int r = 0; r < 1024; r++)
            for (int i = 0; i < 16; i++) begin
                tmp = ($urandom_range(0, 1) == 1) ? int'($urandom) : (int'($urandom_range(0, 4000)) - 2000);
                mem[r][i*24 +: 24] = tmp[23:0];
            end
        for (int r = 0; r < 16; r++)
            for (int i = 0; i < 16; i++) begin
                tmp = r * 16 + i;
                mem[r][i*24 +: 24] = tmp[23:0];
            end
        tmp = 24;     mem[100][0*24 +: 24] = tmp[23:0];
        tmp = -24;    mem[100][1*24 +: 24] = tmp[23:0];
        tmp = 'h7FFFFF; mem[100][2*24 +: 24] = tmp[23:0];
        tmp = -5000;  mem[100][3*24 +: 24] = tmp[23:0];

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Basic free-flowing drain
        mode = 0;
        run_drain(0, 16, 0, "basic");
        chk("basic_latency", first_cyc - start_cyc, 2);
        chk("basic_back_to_back", last_cyc - first_cyc, 15);
        chk("basic_beats", m_beats, 16);
        chk("row5_lane3", got_rows[5][3*8 +: 8], 8'd83);
        chk("row15_lane15_sat", got_rows[15][15*8 +: 8], 8'h7F);

        // Backpressure
        mode = 1;
        run_drain(0, 16, 0, "bp");
        chk("bp_beats", m_beats, 16);
        chk("bp_row9_lane2", got_rows[9][2*8 +: 8], 8'd127);

        // Rounding and saturation
        mode = 0;
        run_drain(100, 1, 4, "round");
        chk("round_pos", got_rows[0][0*8 +: 8], 8'd2);
        chk("round_neg", got_rows[0][1*8 +: 8], 8'hFF);
        chk("sat_hi", got_rows[0][2*8 +: 8], 8'h7F);
        chk("sat_lo", got_rows[0][3*8 +: 8], 8'h80);
        run_drain(100, 1, 31, "clamp");
        chk("clamp_shift_lane2", got_rows[0][2*8 +: 8], 8'd1);
        chk("clamp_shift_lane3", got_rows[0][3*8 +: 8], 8'd0);

        // Address wrap
        run_drain(1022, 4, 3, "wrap");
        chk("wrap_len", addr_q.size(), 4);
        if (addr_q.size() == 4) begin
            chk("wrap_a0", addr_q[0], 1022);
            chk("wrap_a1", addr_q[1], 1023);
            chk("wrap_a2", addr_q[2], 0);
            chk("wrap_a3", addr_q[3], 1);
        end

        // Zero-length drain
        run_drain(0, 0, 0, "zero");
        chk("zero_no_reads", addr_q.size(), 0);

        // Start pulsed mid-drain is ignored
        mode = 1;
        addr_q.delete();
        c0 = drains_done;
        do_start(300, 10, 2);
        repeat (3) @(posedge clk);
        do_start(5, 3, 0);
        wait_done(c0, 200, "ignore");
        chk("ignore_len", addr_q.size(), 10);
        if (addr_q.size() == 10) begin
            chk("ignore_first", addr_q[0], 300);
            chk("ignore_last", addr_q[9], 309);
        end

        // Reset in the middle of a drain
        mode = 0;
        do_start(0, 16, 0);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (m_beats >= 7) break;
        end
        #2;
        chk("pre_reset_valid", out_valid, 1);
        rstn = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_data", out_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        run_drain(200, 6, 1, "post_reset");
        chk("post_reset_base", (addr_q.size() > 0) ? addr_q[0] : -1, 200);
        chk("post_reset_beats", m_beats, 6);

        // Randomized drains
        mode = 2;
        for (int t = 0; t < 10; t++) begin
            int b, n, s;
            b = int'($urandom_range(0, 1023));
            n = int'($urandom_range(1, 40));
            s = int'($urandom_range(0, 31));
            run_drain(b, n, s, "rand");
            chk("rand_beats", m_beats, n);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
